// File: rtl/mu0_control_if.sv
// Signal bundle between the MU0 control unit and its datapath/memory.
// The control unit owns the master modport; the datapath side (or a
// testbench standing in for it) owns the slave modport.
interface mu0_control_if;
    // Status from the datapath
    logic [3:0] F;        // opcode, IR[15:12]
    logic       N;        // ACC[15]
    logic       Z;        // ACC == 0
    logic       Ready;    // memory ready

    // Controls to the datapath and memory
    logic       Addr_sel; // 0 = PC, 1 = IR[11:0]
    logic       X_sel;    // 0 = ACC, 1 = PC
    logic       Y_sel;    // 0 = memory data, 1 = IR[11:0]
    logic [1:0] ALU_fn;   // 00 = Y, 01 = X+Y, 10 = X-Y, 11 = X+1
    logic       PC_En;
    logic       IR_En;
    logic       Acc_En;
    logic       MEMrq;
    logic       RnW;      // 1 = read, 0 = write
    logic       Halted;

    modport master (
        input  F, N, Z, Ready,
        output Addr_sel, X_sel, Y_sel, ALU_fn,
               PC_En, IR_En, Acc_En, MEMrq, RnW, Halted
    );

    modport slave (
        output F, N, Z, Ready,
        input  Addr_sel, X_sel, Y_sel, ALU_fn,
               PC_En, IR_En, Acc_En, MEMrq, RnW, Halted
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 control unit: sequences each instruction through FETCH and EXECUTE,
// parks in HALT on STP or an undefined opcode, and decodes every datapath
// control combinationally from the current state, opcode, flags and Ready.
module mu0_control (
    input  logic          Clk,
    input  logic          nReset,
    mu0_control_if.master cu
);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    localparam logic [1:0] FN_Y    = 2'b00;
    localparam logic [1:0] FN_ADD  = 2'b01;
    localparam logic [1:0] FN_SUB  = 2'b10;
    localparam logic [1:0] FN_INC  = 2'b11;

    state_e state_q, state_d;

    // Opcodes 0-3 touch memory; 4-6 are jumps; everything else stops.
    logic is_mem;
    logic is_jump;
    logic jump_taken;

    assign is_mem  = (cu.F[3:2] == 2'b00);
    assign is_jump = (cu.F == 4'd4) || (cu.F == 4'd5) || (cu.F == 4'd6);

    // Jump condition: JMP always, JGE on ACC >= 0, JNE on ACC != 0.
    always_comb begin
        jump_taken = 1'b0;
        case (cu.F)
            4'd4:    jump_taken = 1'b1;
            4'd5:    jump_taken = ~cu.N;
            4'd6:    jump_taken = ~cu.Z;
            default: jump_taken = 1'b0;
        endcase
    end

    // Next-state selection; memory phases wait on Ready, jumps take one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:   state_d = ST_FETCH;
            ST_FETCH:   if (cu.Ready) state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (is_mem) begin
                    if (cu.Ready) state_d = ST_FETCH;
                end else if (is_jump) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_RESET;
        endcase
    end

    // State register; nReset low forces RESET with no clock edge needed.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_RESET;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge state.
            state_q <= state_d;
        end
    end

    // Output decode; enables only follow Ready so nothing fires in a wait cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        cu.Addr_sel = 1'b0;
        cu.X_sel    = 1'b0;
        cu.Y_sel    = 1'b0;
        cu.ALU_fn   = FN_Y;
        cu.PC_En    = 1'b0;
        cu.IR_En    = 1'b0;
        cu.Acc_En   = 1'b0;
        cu.MEMrq    = 1'b0;
        cu.RnW      = 1'b1;
        cu.Halted   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Instruction read at PC while the ALU forms PC+1.
                cu.Addr_sel = 1'b0;
                cu.MEMrq    = 1'b1;
                cu.RnW      = 1'b1;
                cu.X_sel    = 1'b1;
                cu.ALU_fn   = FN_INC;
                cu.IR_En    = cu.Ready;
                cu.PC_En    = cu.Ready;
            end

            ST_EXECUTE: begin
                if (is_mem) begin
                    cu.Addr_sel = 1'b1;
                    cu.MEMrq    = 1'b1;
                    case (cu.F[1:0])
                        2'd0: begin   // LDA
                            cu.ALU_fn = FN_Y;
                            cu.Acc_En = cu.Ready;
                        end
                        2'd1: begin   // STA: ACC drives the write-data path
                            cu.RnW    = 1'b0;
                            cu.X_sel  = 1'b0;
                        end
                        2'd2: begin   // ADD
                            cu.ALU_fn = FN_ADD;
                            cu.Acc_En = cu.Ready;
                        end
                        default: begin // SUB
                            cu.ALU_fn = FN_SUB;
                            cu.Acc_En = cu.Ready;
                        end
                    endcase
                end else if (is_jump) begin
                    // Jump target is IR[11:0] passed straight through the ALU.
                    cu.Y_sel  = 1'b1;
                    cu.ALU_fn = FN_Y;
                    cu.PC_En  = jump_taken;
                end
            end

            ST_HALT: begin
                cu.Halted = 1'b1;
            end

            default: begin
                // RESET: defaults already describe the idle datapath.
            end
        endcase
    end

endmodule

// File: tb/tb_mu0_control.sv
// Testbench for mu0_control: directed scenarios followed by randomized
// opcode/flag/Ready traffic, each cycle compared against a behavioural model.
module tb_mu0_control;

    logic Clk = 1'b0;
    logic nReset;

    mu0_control_if bus ();

    mu0_control dut (
        .Clk    (Clk),
        .nReset (nReset),
        .cu     (bus)
    );

    always #5 Clk = ~Clk;

    // Model view of where the processor is in its instruction cycle.
    typedef enum {P_IDLE, P_FETCH, P_EXEC, P_STOP} phase_t;

    phase_t ph;
    int     n_pass  = 0;
    int     n_total = 0;

    // Expected {Addr_sel,X_sel,Y_sel,ALU_fn,PC_En,IR_En,Acc_En,MEMrq,RnW,Halted}.
    function automatic logic [10:0] expect_out(phase_t p, logic [3:0] f,
                                               logic n, logic z, logic r);
        logic a, x, y, pc, ir, acc, mq, rnw, h;
        logic [1:0] fn;
        a = 0; x = 0; y = 0; fn = 2'b00; pc = 0; ir = 0; acc = 0;
        mq = 0; rnw = 1; h = 0;
        if (p == P_FETCH) begin
            mq = 1; x = 1; fn = 2'b11; ir = r; pc = r;
        end else if (p == P_EXEC) begin
            if (f <= 4'd3) begin
                a = 1; mq = 1;
                if (f == 4'd1) begin
                    rnw = 0;
                end else begin
                    fn  = (f == 4'd0) ? 2'b00 : (f == 4'd2) ? 2'b01 : 2'b10;
                    acc = r;
                end
            end else if (f <= 4'd6) begin
                y = 1;
                pc = (f == 4'd4) ? 1'b1 : (f == 4'd5) ? ~n : ~z;
            end
        end else if (p == P_STOP) begin
            h = 1;
        end
        return {a, x, y, fn, pc, ir, acc, mq, rnw, h};
    endfunction

    function automatic phase_t next_phase(phase_t p, logic [3:0] f, logic r);
        case (p)
            P_IDLE:  return P_FETCH;
            P_FETCH: return r ? P_EXEC : P_FETCH;
            P_EXEC:  begin
                if (f <= 4'd3) return r ? P_FETCH : P_EXEC;
                if (f <= 4'd6) return P_FETCH;
                return P_STOP;
            end
            default: return P_STOP;
        endcase
    endfunction

    function automatic logic [10:0] observed();
        return {bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.ALU_fn, bus.PC_En,
                bus.IR_En, bus.Acc_En, bus.MEMrq, bus.RnW, bus.Halted};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs,
                         input logic [10:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (Addr,X,Y,FN,PC,IR,ACC,MEM,RnW,Halt)",
                    tag, obs, exp);
    endtask

    // One clock cycle: drive at the falling edge, check, then take the rising edge.
    task automatic cycle(input string tag, input logic [3:0] f, input logic n,
                         input logic z, input logic r);
        bus.F = f; bus.N = n; bus.Z = z; bus.Ready = r;
        #1;
        check(tag, observed(), expect_out(ph, f, n, z, r));
        @(posedge Clk);
        if (nReset) ph = next_phase(ph, f, r);
        @(negedge Clk);
    endtask

    // Asynchronous reset pulse, checked before any edge, then release into FETCH.
    task automatic do_reset(input string tag, input logic r);
        nReset = 1'b0;
        ph     = P_IDLE;
        cycle({tag, "_async"}, bus.F, bus.N, bus.Z, r);
        cycle({tag, "_low"},   bus.F, bus.N, bus.Z, r);
        nReset = 1'b1;
        cycle({tag, "_release"}, bus.F, bus.N, bus.Z, r);
    endtask

    initial begin
        logic [3:0] rf;
        logic       rn, rz;
        int         halt_cycles;

        nReset = 1'b0;
        bus.F = 4'd0; bus.N = 1'b0; bus.Z = 1'b0; bus.Ready = 1'b1;
        ph = P_IDLE;
        @(negedge Clk);

        // Reset held, then released with Ready=1: cycle 0 RESET, cycle 1 FETCH.
        cycle("reset_hold", 4'd0, 0, 0, 1);
        nReset = 1'b1;
        cycle("rst_cycle0", 4'd0, 0, 0, 1);

        // LDA with two wait states in EXECUTE.
        cycle("lda_fetch", 4'd0, 0, 0, 1);
        cycle("lda_wait1", 4'd0, 0, 0, 0);
        cycle("lda_wait2", 4'd0, 0, 0, 0);
        cycle("lda_done",  4'd0, 0, 0, 1);

        // STA, fetch stretched by one wait state.
        cycle("sta_fwait", 4'd1, 0, 0, 0);
        cycle("sta_fetch", 4'd1, 0, 0, 1);
        cycle("sta_exec",  4'd1, 0, 0, 1);

        // ADD / SUB with Ready high.
        cycle("add_fetch", 4'd2, 0, 0, 1);
        cycle("add_exec",  4'd2, 0, 0, 1);
        cycle("sub_fetch", 4'd3, 0, 0, 1);
        cycle("sub_exec",  4'd3, 0, 0, 1);

        // Jumps return to FETCH after one cycle even with Ready=0.
        cycle("jge_n1_fetch", 4'd5, 1, 0, 1);
        cycle("jge_n1_exec",  4'd5, 1, 0, 0);
        cycle("jge_n0_fetch", 4'd5, 0, 0, 1);
        cycle("jge_n0_exec",  4'd5, 0, 0, 0);
        cycle("jne_z1_fetch", 4'd6, 0, 1, 1);
        cycle("jne_z1_exec",  4'd6, 0, 1, 0);
        cycle("jne_z0_fetch", 4'd6, 0, 0, 1);
        cycle("jne_z0_exec",  4'd6, 0, 0, 1);
        cycle("jmp_fetch",    4'd4, 1, 1, 1);
        cycle("jmp_exec",     4'd4, 1, 1, 0);

        // STP: HALT held for 20 cycles whatever Ready does, then reset.
        cycle("stp_fetch", 4'd7, 0, 0, 1);
        cycle("stp_exec",  4'd7, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            cycle("stp_halt", 4'd7, 0, 0, 1'($urandom_range(0, 1)));
        do_reset("stp_reset", 1'b1);

        // Undefined opcode on a fresh run also halts.
        cycle("undef_fetch", 4'hA, 0, 0, 1);
        cycle("undef_exec",  4'hA, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cycle("undef_halt", 4'hA, 0, 0, 1'($urandom_range(0, 1)));
        do_reset("undef_reset", 1'b0);

        // Reset during a FETCH wait abandons the access; FETCH restarts after.
        cycle("midfetch_wait", 4'd0, 0, 0, 0);
        do_reset("midfetch_reset", 1'b0);
        cycle("midfetch_restart", 4'd0, 0, 0, 1);
        cycle("midfetch_exec",    4'd0, 0, 0, 1);

        // Randomized traffic; opcode and flags only change outside EXECUTE.
        rf = 4'd0; rn = 1'b0; rz = 1'b0;
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (ph != P_EXEC) begin
                rf = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(7, 15))
                                                  : 4'($urandom_range(0, 6));
                rn = 1'($urandom_range(0, 1));
                rz = 1'($urandom_range(0, 1));
            end
            if (ph == P_STOP) halt_cycles++;
            if (halt_cycles >= 3 || $urandom_range(0, 60) == 0) begin
                halt_cycles = 0;
                do_reset("rand_reset", 1'($urandom_range(0, 1)));
            end else begin
                cycle("rand", rf, rn, rz, 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
